// File: rtl/word_match_if.sv
// Guess/target scoring bus between guess-entry logic (master) and the word scorer (slave).
interface word_match_if #(
    parameter int LETTERS = 5,
    parameter int W       = 5
);
    logic                 start;
    logic [LETTERS*W-1:0] guess;
    logic [LETTERS*W-1:0] target;
    logic                 busy;
    logic                 done;
    logic [LETTERS-1:0]   green;
    logic [LETTERS-1:0]   yellow;
    logic                 win;
    logic                 word_lt;
    logic                 word_gt;

    modport master (
        output start, guess, target,
        input  busy, done, green, yellow, win, word_lt, word_gt
    );

    modport slave (
        input  start, guess, target,
        output busy, done, green, yellow, win, word_lt, word_gt
    );
endinterface

// File: rtl/word_match_seq.sv
// Sequential Wordle-style scorer: one shared letter comparator walks every (i, j)
// letter pair, then publishes green/yellow/win and lexicographic order in one DONE cycle.
module word_match_seq #(
    parameter int LETTERS = 5,
    parameter int W       = 5
) (
    input logic         clk,
    input logic         rst_n,
    word_match_if.slave bus
);
    localparam int CW = (LETTERS > 1) ? $clog2(LETTERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(LETTERS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t               state, state_nxt;
    logic [LETTERS*W-1:0] guess_q, target_q;
    logic [CW-1:0]        i, j;
    logic [LETTERS-1:0]   cand_green, cand_yellow;
    logic                 decided, lt_q, gt_q;
    logic [LETTERS-1:0]   green_q, yellow_q;
    logic                 win_q, word_lt_q, word_gt_q;

    logic [W-1:0]         a, b;
    logic                 eq, lt, gt, last;
    logic [LETTERS-1:0]   cg_nxt, cy_nxt;
    logic                 dec_nxt, lt_nxt, gt_nxt;

    // Shared comparator plus the candidate-flag update it drives this cycle.
    always_comb begin
        a       = guess_q[i*W +: W];
        b       = target_q[j*W +: W];
        eq      = (a == b);
        lt      = (a < b);
        gt      = (a > b);
        cg_nxt  = cand_green;
        cy_nxt  = cand_yellow;
        dec_nxt = decided;
        lt_nxt  = lt_q;
        gt_nxt  = gt_q;
        if (eq && (i == j)) cg_nxt[i] = 1'b1;
        if (eq && (i != j)) cy_nxt[i] = 1'b1;
        // i ascends, so the first diagonal mismatch is the leftmost differing letter.
        if (!eq && (i == j) && !decided) begin
            dec_nxt = 1'b1;
            lt_nxt  = lt;
            gt_nxt  = gt;
        end
        last = (i == LAST) && (j == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SCAN;
            SCAN:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Words are captured once at start; later input changes are invisible to the scan.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            guess_q  <= bus.guess;
            target_q <= bus.target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i           <= '0;
            j           <= '0;
            cand_green  <= '0;
            cand_yellow <= '0;
            decided     <= 1'b0;
            lt_q        <= 1'b0;
            gt_q        <= 1'b0;
            green_q     <= '0;
            yellow_q    <= '0;
            win_q       <= 1'b0;
            word_lt_q   <= 1'b0;
            word_gt_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        i           <= '0;
                        j           <= '0;
                        cand_green  <= '0;
                        cand_yellow <= '0;
                        decided     <= 1'b0;
                        lt_q        <= 1'b0;
                        gt_q        <= 1'b0;
                    end
                end
                SCAN: begin
                    cand_green  <= cg_nxt;
                    cand_yellow <= cy_nxt;
                    decided     <= dec_nxt;
                    lt_q        <= lt_nxt;
                    gt_q        <= gt_nxt;
                    if (last) begin
                        i         <= '0;
                        j         <= '0;
                        green_q   <= cg_nxt;
                        yellow_q  <= cy_nxt & ~cg_nxt;
                        win_q     <= &cg_nxt;
                        word_lt_q <= lt_nxt;
                        word_gt_q <= gt_nxt;
                    end else if (j == LAST) begin
                        j <= '0;
                        i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.green   = green_q;
    assign bus.yellow  = yellow_q;
    assign bus.win     = win_q;
    assign bus.word_lt = word_lt_q;
    assign bus.word_gt = word_gt_q;
endmodule

// File: tb/tb_word_match_seq.sv
// Bench for word_match_seq: directed word cases plus random traffic, all checked per cycle
// against a loop-based scoring model with a busy-cycle countdown.
module tb_word_match_seq;
    localparam int L = 5;
    localparam int W = 5;

    typedef struct packed {
        logic [L-1:0] gr;
        logic [L-1:0] ye;
        logic         w;
        logic         lt;
        logic         gt;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    word_match_if #(.LETTERS(L), .W(W)) bus();

    word_match_seq #(.LETTERS(L), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoring straight from the game rules, letter by letter.
    function automatic res_t score(input logic [L*W-1:0] g, input logic [L*W-1:0] t);
        res_t r;
        int first;
        r = '0;
        first = -1;
        for (int k = 0; k < L; k++) begin
            if (g[k*W +: W] == t[k*W +: W]) r.gr[k] = 1'b1;
            else if (first < 0) first = k;
        end
        for (int k = 0; k < L; k++)
            if (!r.gr[k])
                for (int m = 0; m < L; m++)
                    if (m != k && g[k*W +: W] == t[m*W +: W]) r.ye[k] = 1'b1;
        r.w = &r.gr;
        if (first >= 0) begin
            r.lt = g[first*W +: W] < t[first*W +: W];
            r.gt = !r.lt;
        end
        return r;
    endfunction

    function automatic logic [L*W-1:0] word5(input int c0, input int c1, input int c2,
                                             input int c3, input int c4);
        logic [L*W-1:0] r;
        r[0*W +: W] = W'(c0);
        r[1*W +: W] = W'(c1);
        r[2*W +: W] = W'(c2);
        r[3*W +: W] = W'(c3);
        r[4*W +: W] = W'(c4);
        return r;
    endfunction

    // Model: busy lasts LETTERS*LETTERS+1 cycles after an accepted start; results land on its last one.
    int m_cnt = 0;
    logic [L*W-1:0] mg, mt;
    res_t m_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_res <= '0;
        end else if (m_cnt == 0) begin
            if (bus.start) begin
                mg    <= bus.guess;
                mt    <= bus.target;
                m_cnt <= L*L + 1;
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) m_res <= score(mg, mt);
        end
    end

    int cyc = 0;
    int done_cnt = 0;
    int done_times[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            chk("busy",    32'(bus.busy),    32'(m_cnt != 0));
            chk("done",    32'(bus.done),    32'(m_cnt == 1));
            chk("green",   32'(bus.green),   32'(m_res.gr));
            chk("yellow",  32'(bus.yellow),  32'(m_res.ye));
            chk("win",     32'(bus.win),     32'(m_res.w));
            chk("word_lt", 32'(bus.word_lt), 32'(m_res.lt));
            chk("word_gt", 32'(bus.word_gt), 32'(m_res.gt));
            if (bus.done) begin
                done_cnt++;
                done_times.push_back(cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    // Start one scoring and wait (bounded) for done; lat counts busy cycles including the done cycle.
    task automatic run(input logic [L*W-1:0] g, input logic [L*W-1:0] t, output int lat);
        @(negedge clk);
        bus.guess  = g;
        bus.target = t;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic chk_out(input string tag, input logic [L-1:0] gr, input logic [L-1:0] ye,
                           input logic w, input logic lt, input logic gt);
        chk({tag, "_green"},  32'(bus.green),   32'(gr));
        chk({tag, "_yellow"}, 32'(bus.yellow),  32'(ye));
        chk({tag, "_win"},    32'(bus.win),     32'(w));
        chk({tag, "_lt"},     32'(bus.word_lt), 32'(lt));
        chk({tag, "_gt"},     32'(bus.word_gt), 32'(gt));
    endtask

    initial begin
        logic [L*W-1:0] crane, nacre, blimp, level, eelll;
        res_t r;
        int lat, d0, busy_n;

        crane = word5(3, 18, 1, 14, 5);
        nacre = word5(14, 1, 3, 18, 5);
        blimp = word5(2, 12, 9, 13, 16);
        level = word5(12, 5, 22, 5, 12);
        eelll = word5(5, 5, 12, 12, 12);

        bus.start  = 1'b0;
        bus.guess  = '0;
        bus.target = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk_out("rst", 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Hand-computed pins on the model itself.
        r = score(nacre, crane);
        chk("model_nacre", 32'(r), 32'({5'b10000, 5'b01111, 1'b0, 1'b0, 1'b1}));
        r = score(eelll, level);
        chk("model_eelll", 32'(r), 32'({5'b10010, 5'b01101, 1'b0, 1'b1, 1'b0}));

        run(crane, crane, lat);
        chk("crane_latency", 32'(lat - 1), 32'd25);
        chk("crane_done", 32'(bus.done), 32'd1);
        chk_out("crane", 5'b11111, 5'b00000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("crane_done_drop", 32'(bus.done), 32'd0);
        chk("crane_busy_drop", 32'(bus.busy), 32'd0);

        // Reset during a scan.
        @(negedge clk);
        bus.guess  = nacre;
        bus.target = crane;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk_out("midrst", 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

        busy_n = 0;
        run(nacre, crane, lat);
        chk("nacre_latency", 32'(lat - 1), 32'd25);
        chk_out("nacre", 5'b10000, 5'b01111, 1'b0, 1'b0, 1'b1);

        run(blimp, crane, lat);
        chk("blimp_latency", 32'(lat - 1), 32'd25);
        chk_out("blimp", 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0);

        run(eelll, level, lat);
        chk_out("eelll", 5'b10010, 5'b01101, 1'b0, 1'b1, 1'b0);

        // Start and input changes while busy are ignored.
        @(negedge clk);
        bus.guess  = blimp;
        bus.target = crane;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        d0 = done_cnt;
        repeat (4) @(negedge clk);
        bus.guess = crane;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 60) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_n++;
        end
        chk_out("protect", 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        chk("protect_one_done", 32'(done_cnt - d0), 32'd1);

        // Start held high retriggers every 27 cycles.
        done_times.delete();
        bus.guess  = crane;
        bus.target = crane;
        bus.start  = 1'b1;
        repeat (60) @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        chk("hold_pulses", 32'(done_times.size()), 32'd3);
        for (int k = 1; k < done_times.size(); k++)
            chk("hold_spacing", 32'(done_times[k] - done_times[k-1]), 32'd27);

        // Random traffic, small alphabet half the time to force duplicates.
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            for (int k = 0; k < L; k++) begin
                if ($urandom_range(0, 1) == 0) begin
                    bus.guess[k*W +: W]  = W'($urandom_range(0, 3));
                    bus.target[k*W +: W] = W'($urandom_range(0, 3));
                end else begin
                    bus.guess[k*W +: W]  = W'($urandom_range(0, 26));
                    bus.target[k*W +: W] = W'($urandom_range(0, 26));
                end
            end
            if ($urandom_range(0, 4) == 0) bus.guess = bus.target;
            bus.start = ($urandom_range(0, 2) == 0);
        end
        bus.start = 1'b0;
        repeat (30) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/word_match_seq.md
Name: word_match_seq

Overview:
- Sequential Wordle-style scorer for the WordPanel game.
- Takes a guessed word and a target word, each LETTERS letters of W bits.
- Time-shares a single W-bit magnitude comparator (eq/lt/gt outputs), one letter pair per clock.
- Produces per-letter green (right letter, right place) and yellow (letter present elsewhere) flags, a win flag and a lexicographic order result. Sits between the keyboard/guess-entry logic and the panel display driver.

Parameters:
LETTERS, 5, letters per word
W, 5, bits per letter code (A=1 … Z=26, 0 = blank)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request scoring; sampled only in IDLE
guess  in  LETTERS*W  guessed word; letter k at bits [k*W +: W], k=0 leftmost
target  in  LETTERS*W  target word, same packing
busy  out  1  high while in SCAN or DONE
done  out  1  one-cycle pulse when results are valid
green  out  LETTERS  bit k = guess[k]==target[k]
yellow  out  LETTERS  bit k = guess[k] equals some target[j], j!=k, and green[k]=0
win  out  1  all green bits set
word_lt  out  1  guess < target lexicographically (first differing letter decides)
word_gt  out  1  guess > target lexicographically

Behaviour:
- Reset (async, rst_n=0): state IDLE; counters i,j=0. busy, done, green, yellow, win, word_lt, word_gt all 0. Reset mid-SCAN aborts the scan; no done pulse is produced.
- States: IDLE, SCAN, DONE.
- IDLE: on an edge with start=1, latch guess and target into internal registers, clear the working flags (candidate green, candidate yellow, order-decided, lt, gt), set i=j=0, go to SCAN. Later changes on the guess/target inputs are ignored.
- SCAN: one comparator evaluation per cycle of latched guess[i] vs latched target[j].
  - eq and i==j: set candidate green[i].
  - eq and i!=j: set candidate yellow[i].
  - i==j, not eq, order not yet decided: record lt/gt from the comparator and mark order decided. Because i ascends, the leftmost differing letter wins.
  - Counters: j increments each cycle; when j wraps from LETTERS-1 to 0, i increments.
  - After the compare with i=j=LETTERS-1, go to DONE.
- SCAN takes exactly LETTERS*LETTERS cycles (25 at default).
- Entry into DONE, on the same edge as the final compare:
  - green <= candidate green, including the final compare.
  - yellow <= candidate yellow & ~green.
  - win <= &green.
  - word_lt/word_gt <= recorded order; both 0 if the words are equal.
  - done=1.
- done therefore rises exactly LETTERS*LETTERS edges after the start-sampling edge.
- DONE: lasts one cycle, then IDLE. done returns to 0 and busy to 0.
- start while busy is ignored and not queued. start held high continuously re-triggers on the first IDLE cycle.
- Outputs green/yellow/win/word_lt/word_gt hold their last result until the next DONE. They are never partially updated mid-scan.
- Duplicate letters: yellow is presence-based. A guess letter is yellow if it appears at any other target position, regardless of multiplicity.
- Blank (0) letters compare like any code; no special handling.
- word_lt and word_gt are never both 1.

Test Plan:
- Reset mid-scan: pulse rst_n low at cycle 10 of a scan -> all outputs 0 immediately, no done pulse, IDLE after release; the next start scores normally.
- Exact match: guess=target="CRANE" (3,18,1,14,5), start 1 cycle -> done exactly 25 edges later for one cycle; green=5'b11111, yellow=0, win=1, word_lt=word_gt=0; busy high for 26 cycles total.
- Anagram/mixed: target="CRANE", guess="NACRE" (14,1,3,18,5) -> green bit4 only, yellow=5'b01111, win=0, word_gt=1 (N>C).
- No overlap plus order: target="CRANE", guess="BLIMP" -> green=0, yellow=0, word_lt=1, word_gt=0.
- Busy protection: change the guess inputs and pulse start at cycle 5 of a scan -> results reflect the originally latched words, with exactly one done pulse. Hold start high for 60 cycles -> done pulses spaced exactly 27 cycles apart.
- Duplicates: target="LEVEL", guess="EELLL" -> green=5'b10010 (bits 1,4), yellow=5'b01101, word_lt=1 (E<L).
